// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN activation LUT: default geometry, loader
// state encoding and the address/entry types.
package cnn_pkg;

  localparam int DEF_MEM_WIDTH  = 5;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } lut_state_e;

  typedef logic        [DEF_MEM_WIDTH-1:0]  lut_addr_t;
  typedef logic signed [DEF_DATA_WIDTH-1:0] lut_data_t;

endpackage

// File: rtl/lut_mem.sv
// Activation LUT storage: one write port, one registered read port.
// A same-cycle read and write to one address returns the old contents.
module lut_mem
  import cnn_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [MEM_WIDTH-1:0]         waddr,
  input  logic signed [DATA_WIDTH-1:0] wdata,
  input  logic                         re,
  input  logic [MEM_WIDTH-1:0]         raddr,
  output logic signed [DATA_WIDTH-1:0] rdata,
  output logic                         rvalid
);

  localparam int DEPTH = 2 ** MEM_WIDTH;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                         rvalid_d, rvalid_q;

  // Write port: store entries bit-exact.
  // NOTE: the storage array has no reset so it maps onto RAM; only the read
  // pipeline registers below are reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Next read result: capture on request, otherwise hold the last value.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (re) begin
      rdata_d  = mem[raddr];
      rvalid_d = 1'b1;
    end
  end

  // Read pipeline registers; sampling mem here before the write lands gives
  // read-before-write on a collision.
  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // pre-edge values, which is what makes the collision return old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: rtl/act_lut_loader.sv
// Writer side of the activation LUT: accepts a start command and a stream of
// 2**MEM_WIDTH entries over valid/ready, fills the LUT from address 0, and
// exposes a one-cycle-latency read port plus a table_valid flag.
module act_lut_loader
  import cnn_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         wr_valid,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         wr_ready,
  output logic                         load_busy,
  output logic                         load_done,
  output logic                         table_valid,
  input  logic                         rd_en,
  input  logic [MEM_WIDTH-1:0]         rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid
);

  localparam logic [MEM_WIDTH-1:0] LAST_ADDR = {MEM_WIDTH{1'b1}};

  lut_state_e           state_d, state_q;
  logic [MEM_WIDTH-1:0] wr_addr_d, wr_addr_q;
  logic                 table_valid_d, table_valid_q;
  logic                 mem_we;

  // Next-state logic: load sequencing, address counter and table flag.
  // Abort wins over a same-cycle handshake so that entry is dropped.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    table_valid_d = table_valid_q;
    mem_we        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d       = LOAD;
          wr_addr_d     = '0;
          table_valid_d = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wr_valid) begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + MEM_WIDTH'(1);
          if (wr_addr_q == LAST_ADDR) begin
            state_d       = DONE;
            table_valid_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, address and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      table_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      table_valid_q <= table_valid_d;
    end
  end

  // Handshake and status outputs decode the state register only, so none of
  // them depend combinationally on wr_valid.
  assign wr_ready    = (state_q == LOAD);
  assign load_busy   = (state_q == LOAD);
  assign load_done   = (state_q == DONE);
  assign table_valid = table_valid_q;

  lut_mem #(
    .MEM_WIDTH (MEM_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lut_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data),
    .rvalid(rd_valid)
  );

endmodule
